// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry and the loader state
// encoding, reused by the loader, the fetch stage and the CPU top.
package cpu_pkg;

  localparam int unsigned IMEM_ADDR_W = 11;
  localparam int unsigned IMEM_DEPTH  = 2048;
  localparam int unsigned INSTR_W     = 32;

  // Width of the big-endian word-count field at the head of a load frame.
  localparam int unsigned LEN_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } imem_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs four stream bytes (first byte = MSB) into one instruction word.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        restart at byte 0
//   load       accept byte_in at the current byte index
//   byte_in    stream byte
//   word_out   last completed word; changes only when a word completes
//   last_byte  the next loaded byte completes a word
module imem_word_assembler
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word_out,
  output logic               last_byte
);

  localparam int unsigned SHIFT_W = INSTR_W - 8;

  logic [1:0]         idx;
  logic [SHIFT_W-1:0] shift_q;

  // The first three bytes collect in a shift register so word_out stays
  // stable until the whole word is present, and can drive the RAM directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 2'd0;
      shift_q  <= '0;
      word_out <= '0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (load) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        word_out <= {shift_q, byte_in};
      end else begin
        shift_q <= {shift_q[SHIFT_W-9:0], byte_in};
      end
    end
  end

  assign last_byte = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream (16-bit big-endian
// word count N, then N*4 instruction bytes MSB first) and writes the words to
// the instruction RAM from address 0 upward while holding the CPU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a frame (honoured only when idle)
//   s_data/s_valid      stream byte and its valid
//   s_ready             loader accepts a byte this cycle
//   mem_wea/addr/din    single-port RAM write interface
//   cpu_hold            CPU fetch held while a frame is in progress
//   busy                loader not idle
//   done                one-cycle pulse at frame completion
//   err                 sticky oversize-length error
//   words_written       words written in the current/last frame
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned WW_W  = ADDR_W + 1;
  localparam int unsigned CMP_W = LEN_W + 1;

  imem_state_e      state;
  logic [LEN_W-1:0] len;
  logic             xfer_c;
  logic             last_byte;
  logic             asm_clr_c;
  logic             asm_load_c;
  logic [LEN_W-1:0] len_c;
  logic [WW_W-1:0]  ww_next_c;

  assign xfer_c     = s_valid && s_ready;
  assign asm_clr_c  = xfer_c && (state == LEN_LO);
  assign asm_load_c = xfer_c && (state == DATA);
  // Full word count as it becomes known on the low-byte transfer.
  assign len_c      = {len[LEN_W-1:8], s_data};
  assign ww_next_c  = words_written + WW_W'(1);

  // Assembled word feeds the RAM data port directly; it only changes when a
  // word completes, so it is stable through WRITE and holds afterwards.
  imem_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr_c),
    .load      (asm_load_c),
    .byte_in   (s_data),
    .word_out  (mem_din),
    .last_byte (last_byte)
  );

  // Frame FSM; every output is set alongside the transition into its state.
  // words_written doubles as the write address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      s_ready       <= 1'b0;
      mem_wea       <= 1'b0;
      mem_addr      <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= LEN_HI;
            s_ready       <= 1'b1;
            cpu_hold      <= 1'b1;
            busy          <= 1'b1;
            err           <= 1'b0;
            words_written <= '0;
          end
        end
        LEN_HI: begin
          if (xfer_c) begin
            len[LEN_W-1 -: 8] <= s_data;
            state             <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer_c) begin
            len[7:0] <= s_data;
            if (len_c == '0) begin
              state   <= DONE;
              s_ready <= 1'b0;
              done    <= 1'b1;
            end else if (CMP_W'(len_c) > CMP_W'(DEPTH)) begin
              state   <= ERR;
              s_ready <= 1'b0;
              err     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer_c && last_byte) begin
            state    <= WRITE;
            s_ready  <= 1'b0;
            mem_wea  <= 1'b1;
            mem_addr <= words_written[ADDR_W-1:0];
          end
        end
        WRITE: begin
          mem_wea       <= 1'b0;
          words_written <= ww_next_c;
          if (CMP_W'(ww_next_c) == CMP_W'(len)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= DATA;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        ERR: begin
          state    <= IDLE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame vectors from a table plus hand-written
// reset, boundary-length and start-while-busy sequences.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = IMEM_ADDR_W;
  localparam int unsigned DATA_W = INSTR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(IMEM_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .mem_wea       (mem_wea),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  // Frame record: bytes left-justified (byte 0 in [95:88]).
  typedef struct {
    logic [95:0] bytes;
    int          nb;
    int          gap;
    int          exp_nwr;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic        exp_err;
    int          exp_ww;
    logic        exp_done;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];

  // RAM-side observer: records every write strobe mid-cycle.
  always @(negedge clk) begin
    if (mem_wea) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_din);
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},  32'(s_ready), 32'd0);
    check({tag, "_mem_wea"},  32'(mem_wea), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"},  32'(mem_din), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_ww"},       32'(words_written), 32'd0);
  endtask

  // Offer one byte after `gap` idle cycles; completes on the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      step();
    end
    s_valid = 1'b1;
    s_data  = b;
    k = 0;
    while (!s_ready && k < 50) begin
      step();
      k++;
    end
    check("ready_wait", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input int vi, input int start_pulse_at);
    vec_t v;
    int   k;
    v = vecs[vi];
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    check("ww_cleared", 32'(words_written), 32'd0);
    for (int i = 0; i < v.nb; i++) begin
      if (i == start_pulse_at) pulse_start();
      send_byte(v.bytes[95-8*i -: 8], v.gap);
      if (i >= 2 && ((i - 2) % 4) == 3) begin
        check("wea_latency", 32'(mem_wea), 32'd1);
        check("ready_low_in_write", 32'(s_ready), 32'd0);
      end
    end
    k = 0;
    while (busy && !done && k < 20) begin
      step();
      k++;
    end
    if (v.exp_done) begin
      check("done_pulse", 32'(done), 32'd1);
      check("hold_during_done", 32'(cpu_hold), 32'd1);
      step();
      check("hold_released", 32'(cpu_hold), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
    end
    check("busy_returns_idle", 32'(busy), 32'd0);
    repeat (3) step();
    check("err_final", 32'(err), 32'(v.exp_err));
    check("words_written", 32'(words_written), 32'(v.exp_ww));
    check("num_writes", 32'(wr_addr_q.size()), 32'(v.exp_nwr));
    check("num_done", 32'(done_cnt), 32'(v.exp_done));
    if (v.exp_nwr >= 1 && wr_addr_q.size() >= 1) begin
      check("addr0", 32'(wr_addr_q[0]), 32'd0);
      check("data0", wr_data_q[0], v.exp_w0);
    end
    if (v.exp_nwr >= 2 && wr_addr_q.size() >= 2) begin
      check("addr1", 32'(wr_addr_q[1]), 32'd1);
      check("data1", wr_data_q[1], v.exp_w1);
      check("mem_din_holds", mem_din, v.exp_w1);
      check("mem_addr_holds", 32'(mem_addr), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{96'h0002_0001000F_004100FF_0000, 10, 0, 2, 32'h0001000F, 32'h004100FF, 1'b0, 2, 1'b1};
    vecs[1] = '{96'h0002_0001000F_004100FF_0000, 10, 3, 2, 32'h0001000F, 32'h004100FF, 1'b0, 2, 1'b1};
    vecs[2] = '{96'h0000_00000000_00000000_0000,  2, 0, 0, 32'h0,        32'h0,        1'b0, 0, 1'b1};
    vecs[3] = '{96'h0801_00000000_00000000_0000,  2, 0, 0, 32'h0,        32'h0,        1'b1, 0, 1'b0};
    vecs[4] = '{96'h0001_DEADBEEF_00000000_0000,  6, 1, 1, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1'b1};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Table vectors; vector 4 follows the oversize frame and clears its err.
    for (int vi = 0; vi < 5; vi++) run_frame(vi, -1);

    // start pulsed during DATA (after the first data byte) must be ignored.
    run_frame(0, 3);

    // Reset after six data bytes: only addr0 written, then a clean reload.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(vecs[0].bytes[95-8*i -: 8], 0);
    rst = 1'b1;
    step();
    check_all_zero("midframe_rst");
    rst = 1'b0;
    repeat (2) step();
    check("rst_num_writes", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() >= 1) begin
      check("rst_addr0", 32'(wr_addr_q[0]), 32'd0);
      check("rst_data0", wr_data_q[0], 32'h0001000F);
    end
    run_frame(0, -1);

    // N == DEPTH is accepted: loader enters DATA and writes word 0.
    pulse_start();
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    check("depth_ready", 32'(s_ready), 32'd1);
    check("depth_no_err", 32'(err), 32'd0);
    check("depth_busy", 32'(busy), 32'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    check("depth_wea", 32'(mem_wea), 32'd1);
    check("depth_addr", 32'(mem_addr), 32'd0);
    check("depth_din", mem_din, 32'h11223344);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: accepts a framed byte stream and writes 32-bit instruction words into the instruction block RAM (single-port, wea/addr/din) from address 0 upward.
- The fetch logic later reads these words back into IR.
- Holds the CPU (cpu_hold) for the whole load, then pulses done.
- Frame format, big-endian:
  - 2-byte word count N.
  - N×4 instruction bytes; the first byte of each word is din[31:24].

Parameters:
- ADDR_W, 11, memory address width.
- DATA_W, 32, instruction word width. Fixed at 4 bytes; other values are unsupported.
- DEPTH, 2048, maximum words accepted (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte this cycle.
- mem_wea  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory write address.
- mem_din  out  DATA_W  memory write data.
- cpu_hold  out  1  high while a frame is in progress; the CPU fetch counter is held at 0 while high.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  sticky length error; cleared by the next accepted start or by rst.
- words_written  out  ADDR_W+1  count of words written in the current/last frame.

Behaviour:
- Reset (rst=1 on a clk edge): state=IDLE. All outputs are 0: s_ready, mem_wea, mem_addr, mem_din, cpu_hold, busy, done, err, words_written. Internal byte index and length are also cleared.
- Reset mid-frame aborts the frame: no further writes, and RAM contents already written are left as they are.
- Byte transfer occurs only when s_valid && s_ready on a clk edge. s_data is ignored otherwise.
- States:
  - IDLE:
    - s_ready=0.
    - start=1 → LEN_HI. On entry: err cleared, words_written cleared, address counter cleared.
    - cpu_hold and busy assert the cycle after start is sampled.
  - LEN_HI:
    - s_ready=1.
    - On transfer: N[15:8]=s_data → LEN_LO.
  - LEN_LO:
    - s_ready=1.
    - On transfer, N[7:0]=s_data, then evaluate N:
      - N==0 → DONE.
      - N>DEPTH → ERR.
      - otherwise → DATA, byte index=0.
  - DATA:
    - s_ready=1.
    - Each transfer shifts s_data into the assembly register at byte index (0→[31:24], 3→[7:0]) and increments the index modulo 4.
    - The transfer with index 3 → WRITE.
  - WRITE (exactly one cycle):
    - s_ready=0.
    - mem_wea=1, mem_din=assembled word, mem_addr=current word address.
    - Next edge: address+1, words_written+1.
    - If words_written+1==N → DONE, else → DATA.
  - DONE (one cycle):
    - done=1.
    - Next edge: cpu_hold=0, busy=0 → IDLE.
  - ERR (one cycle):
    - err set (sticky), no writes.
    - → IDLE, cpu_hold released.
- Latency: mem_wea is high in the cycle immediately after the 4th byte of a word is accepted. Peak throughput is 1 word per 5 cycles.
- mem_wea is 0 in every state except WRITE. mem_addr and mem_din hold their last values when mem_wea=0.
- An address wrap cannot occur: N≤DEPTH is enforced, so the last address is N-1 ≤ DEPTH-1.
- start while busy is ignored; no restart and no error.
- s_valid stalls (s_valid low) in any state simply wait, with no timeout.
- words_written holds its final value in IDLE until the next start.

Decomposition:
- Shared package cpu_pkg holds:
  - State enum: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
  - IMEM_ADDR_W=11, IMEM_DEPTH=2048, INSTR_W=32.
  - Reused by the fetch stage and the CPU top.
- One sub-module: imem_word_assembler. It covers the 8→32 shift register and byte index, with ports clk, rst, clr, load, byte_in, word_out, last_byte.
- The FSM and counters stay in imem_loader.

Test Plan:
- Two-word frame:
  - Stimulus: start, then bytes 00 02 | 00 01 00 0F | 00 41 00 FF, with s_valid always high.
  - Required: writes addr0=0x0001000F and addr1=0x004100FF, each with mem_wea high 1 cycle after the 4th byte; done pulse; words_written=2; cpu_hold drops the cycle after done.
- Backpressure and gaps:
  - Stimulus: same frame with s_valid low for 3 cycles between every byte.
  - Required: identical RAM contents; mem_wea asserted exactly 2 times; s_ready=0 in the WRITE cycles.
- Zero length:
  - Stimulus: start, bytes 00 00.
  - Required: no mem_wea; done 1 cycle after 2nd byte; err=0; words_written=0.
- Oversize length:
  - Stimulus: start, bytes 08 01 (N=2049).
  - Required: no writes; err=1 and stays 1; busy returns to 0. A following start clears err.
- Reset mid-frame:
  - Stimulus: assert rst after 6 data bytes of a 2-word frame.
  - Required: all outputs 0 on the next edge; only addr0 written; a subsequent full frame loads correctly from addr0.
- start while busy:
  - Stimulus: pulse start during DATA.
  - Required: ignored; frame completes normally with the expected words_written.
